conv2d_stream: RTL and testbench
================================

// Module: conv2d_stream
// PURPOSE
//  Streaming KxK 2D convolution of a raster-ordered grayscale image, one pixel per beat.
//  Parametrised successor of the fixed 3x3/512-wide convolver. Generalises width, kernel size,
//  coefficient width and output scaling; adds true ready/valid backpressure and frame restart.
//  Sits between the pixel source and the sink in the image pipeline.
//  Input rows are pre-padded: each row carries IMG_W+K-1 pixels.
// PARAMETERS
//  IMG_W   512  output pixels per row; input row length is IMG_W+K-1
//  K       3    kernel dimension, odd, 3..7
//  DATAW   8    pixel width, unsigned
//  COEFW   8    coefficient width, signed two's complement
//  SHIFT   0    arithmetic right shift applied to the sum before saturation, 0..COEFW
// PORTS
//  clk      in   1            operating clock
//  reset    in   1            synchronous, active-high
//  i_f      in   K*K*COEFW    coefficients, row-major; i_f[COEFW-1:0] is f[0][0]
//  i_valid  in   1            input pixel valid
//  i_sof    in   1            qualifies the i_x beat as the first pixel of a frame
//  i_x      in   DATAW        input pixel
//  o_ready  out  1            block accepts a beat this cycle
//  i_ready  in   1            sink accepts o_y this cycle
//  o_valid  out  1            o_y valid
//  o_y      out  DATAW        output pixel, saturated to [0, 2^DATAW-1]
// BEHAVIOUR
//  - Reset clears the coefficient register, line buffers, column/row counters and pipeline valids.
//    Outputs during reset and on the first cycle after it: o_valid=0, o_y=0, o_ready=1.
//  - Input accept: i_valid && o_ready. Output transfer: o_valid && i_ready.
//    stall = o_valid && !i_ready, and o_ready = !stall.
//    While stall is asserted, every pipeline register, counter and line buffer holds its value.
//  - Line buffer: K-1 rows of IMG_W+K-1 pixels plus a KxK window shift register.
//    Column counter col runs 0..IMG_W+K-2 and wraps to 0; row counter row increments on each wrap
//    and saturates at K-1.
//  - Window completion: an accepted pixel with col>=K-1 and row==K-1 completes a window.
//    That window's output is centred on input column col-(K-1)/2.
//    Each row therefore yields exactly IMG_W outputs, and the first K-1 rows of a frame yield none.
//  - Pipeline, 2 stages:
//    S1 registers the K*K products. Each product is coef * {1'b0,pixel} and is COEFW+DATAW+1 bits signed.
//    S2 registers the saturated result into o_y and o_valid.
//    Latency: the completing beat is accepted in cycle n; o_valid=1 in cycle n+2, absent stalls.
//  - Arithmetic:
//    The accumulator is ACCW = COEFW+DATAW+1+$clog2(K*K) bits signed and does not overflow.
//    The sum is shifted by SHIFT with an arithmetic shift.
//    The result clamps to 0 if negative and to 2^DATAW-1 if above; otherwise it takes the low DATAW bits.
//  - Frame restart: an accepted beat with i_sof=1 captures i_f into the coefficient register.
//    That beat is stored at col=0 and sets row=0. Windows from the old frame still in S1/S2 drain normally.
//    i_sof on a non-accepted cycle is ignored.
//    i_sof mid-row abandons the partial row; no output is produced for it.
//  - Coefficients are constant between accepted i_sof beats; i_f is ignored at all other times.
//  - o_valid falls only after a transfer with no new result behind it; it never drops while stalled.
//  - If reset is asserted mid-frame, the next frame must begin with an i_sof beat; outputs are undefined without it.
// CONFIGURATION
//  CONV2D_ROUND_EN
//   - Defined: 2^(SHIFT-1) is added to the sum before the shift (round half up); no effect when SHIFT=0.
//   - Undefined: the shift truncates toward negative infinity.
// TESTING
//  1. Setup: K=3, IMG_W=8, center coefficient 1 and all others 0, 5 rows of 10 pixels with value row*16+col,
//     i_ready=1. Required: 24 outputs equal to the unpadded interior pixels, each 2 cycles after its
//     completing beat.
//  2. All coefficients 1 and all pixels 255. Required: sum 2295, o_y=255.
//     Then f[1][1]=-1 with all others 0. Required: o_y=0.
//  3. Backpressure: as scenario 1 but i_ready toggles randomly at 50%.
//     Required: identical output sequence, and o_valid and o_y held stable while i_ready=0.
//  4. SHIFT=2, all coefficients 1, 3x3 patch of value 3 (sum 27).
//     Required: o_y=6 without CONV2D_ROUND_EN and o_y=7 with it.
//  5. Frame restart: i_sof in the middle of row 3 with new coefficients.
//     Required: pending old-frame outputs drain, then no outputs until row 2 of the new frame completes,
//     and those outputs use the new coefficients.
//  6. Reset asserted in the middle of a stalled output.
//     Required: o_valid=0 and o_y=0 on the next cycle, then a clean new frame runs identical to scenario 1.

Source files
------------

// File: rtl/conv2d_stream.sv
// Streaming KxK 2D convolution over pre-padded raster rows, with ready/valid flow control.
// Build option: define CONV2D_ROUND_EN to round half up before the SHIFT (default truncates).
module conv2d_stream #(
    parameter int IMG_W = 512,
    parameter int K     = 3,
    parameter int DATAW = 8,
    parameter int COEFW = 8,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [K*K*COEFW-1:0] i_f,
    input  logic                 i_valid,
    input  logic                 i_sof,
    input  logic [DATAW-1:0]     i_x,
    output logic                 o_ready,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [DATAW-1:0]     o_y
);
    localparam int RW   = IMG_W + K - 1;
    localparam int CW   = $clog2(RW);
    localparam int RWID = $clog2(K);
    localparam int NT   = K * K;
    localparam int PW   = COEFW + DATAW + 1;
    localparam int ACCW = PW + $clog2(NT);
    localparam int RND  = (2 ** SHIFT) / 2;
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** DATAW) - 1);

    logic [NT-1:0][COEFW-1:0]        coef_q;
    logic [K-2:0][RW-1:0][DATAW-1:0] lb_q;
    logic [K-1:0][K-1:0][DATAW-1:0]  win_q, win_d;
    logic [K-1:0][DATAW-1:0]         newcol;
    logic [CW-1:0]                   col_q, col_d, wcol;
    logic [RWID-1:0]                 row_q, row_d;
    logic [NT-1:0][PW-1:0]           prod_q, prod_d;
    logic [2:1]                      vld_pipe_q;
    logic [DATAW-1:0]                y_q, y_d;
    logic                            stall, accept, complete;
    logic signed [ACCW-1:0]          sum, sum_sh;

    assign stall    = vld_pipe_q[2] && !i_ready;
    assign o_ready  = !stall;
    assign accept   = i_valid && o_ready;
    // A start-of-frame beat always lands in column 0, whatever the counter says.
    assign wcol     = i_sof ? '0 : col_q;
    assign complete = accept && !i_sof && (col_q >= CW'(K - 1)) && (row_q == RWID'(K - 1));
    assign o_valid  = vld_pipe_q[2];
    assign o_y      = y_q;

    // Vertical column for this beat: K-1 buffered rows (oldest first) plus the live pixel.
    for (genvar r = 0; r < K - 1; r++) begin : g_col
        assign newcol[r] = lb_q[r][wcol];
    end
    assign newcol[K-1] = i_x;

    for (genvar r = 0; r < K; r++) begin : g_win
        for (genvar c = 0; c < K - 1; c++) begin : g_sh
            assign win_d[r][c] = win_q[r][c+1];
        end
        assign win_d[r][K-1] = newcol[r];
        for (genvar c = 0; c < K; c++) begin : g_tap
            assign prod_d[r*K+c] = PW'($signed(coef_q[r*K+c]) * $signed({1'b0, win_d[r][c]}));
        end
    end

    always_comb begin
        sum = '0;
        for (int t = 0; t < NT; t++) begin
            sum = sum + ACCW'($signed(prod_q[t]));
        end
`ifdef CONV2D_ROUND_EN
        sum = sum + ACCW'(RND);
`endif
        sum_sh = sum >>> SHIFT;
        if (sum_sh[ACCW-1]) begin
            y_d = '0;
        end else if (sum_sh > SAT_MAX) begin
            y_d = '1;
        end else begin
            y_d = sum_sh[DATAW-1:0];
        end
    end

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (i_sof) begin
            col_d = CW'(1);
            row_d = '0;
        end else if (col_q == CW'(RW - 1)) begin
            col_d = '0;
            if (row_q != RWID'(K - 1)) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coef_q     <= '0;
            lb_q       <= '0;
            win_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            prod_q     <= '0;
            vld_pipe_q <= '0;
            y_q        <= '0;
        end else if (!stall) begin
            vld_pipe_q <= {vld_pipe_q[1], complete};
            if (vld_pipe_q[1]) begin
                y_q <= y_d;
            end
            if (complete) begin
                prod_q <= prod_d;
            end
            if (accept) begin
                if (i_sof) begin
                    coef_q <= i_f;
                end
                win_q <= win_d;
                col_q <= col_d;
                row_q <= row_d;
                for (int r = 0; r < K - 2; r++) begin
                    lb_q[r][wcol] <= lb_q[r+1][wcol];
                end
                lb_q[K-2][wcol] <= i_x;
            end
        end
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: table vectors, fixed pattern frames and randomized frames against
// a window-sum reference model; a SHIFT=2 instance runs alongside on the same stimulus.
module tb_conv2d_stream;
    localparam int IMG_W = 8, K = 3, DATAW = 8, COEFW = 8;
    localparam int RW = IMG_W + K - 1, FW = K * K * COEFW;
`ifdef CONV2D_ROUND_EN
    localparam int R_EN = 1;
`else
    localparam int R_EN = 0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic [FW-1:0] i_f = '0;
    logic i_valid = 1'b0, i_sof = 1'b0, i_ready = 1'b1;
    logic [DATAW-1:0] i_x = '0;
    logic o_ready, o_valid, s_ready, s_valid;
    logic [DATAW-1:0] o_y, s_y;

    always #5 clk = ~clk;

    conv2d_stream #(.IMG_W(IMG_W), .K(K), .DATAW(DATAW), .COEFW(COEFW), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .i_f(i_f), .i_valid(i_valid), .i_sof(i_sof), .i_x(i_x),
        .o_ready(o_ready), .i_ready(i_ready), .o_valid(o_valid), .o_y(o_y));
    conv2d_stream #(.IMG_W(IMG_W), .K(K), .DATAW(DATAW), .COEFW(COEFW), .SHIFT(2)) dut_s (
        .clk(clk), .reset(reset), .i_f(i_f), .i_valid(i_valid), .i_sof(i_sof), .i_x(i_x),
        .o_ready(s_ready), .i_ready(i_ready), .o_valid(s_valid), .o_y(s_y));

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: store the frame as a 2D image and sum each KxK neighbourhood directly.
    typedef struct { int sum; int cyc; } exp_t;
    exp_t q[$];
    int img[0:7][0:RW-1];
    int mf[0:K-1][0:K-1];
    int mr = 0, mc = 0;

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic int shr(input int v);
        return (R_EN != 0) ? ((v + 2) >>> 2) : (v >>> 2);
    endfunction

    task automatic model_accept(input int x, input bit sof, input logic [FW-1:0] f);
        int s;
        if (sof) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    mf[i][j] = int'($signed(f[(i*K+j)*COEFW +: COEFW]));
            mr = 0;
            mc = 0;
        end
        img[mr % 8][mc] = x;
        if (mr >= K - 1 && mc >= K - 1) begin
            s = 0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    s += mf[i][j] * img[(mr - K + 1 + i) % 8][mc - K + 1 + j];
            q.push_back('{s, cyc});
        end
        mc++;
        if (mc == RW) begin
            mc = 0;
            mr++;
        end
    endtask

    // Output monitor / scoreboard, sampled on the falling edge.
    bit lat_chk = 1'b1, prev_stall = 1'b0;
    int prev_y, prev_ys;
    int rx_y[$], rx_ys[$];
    exp_t e_m;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(o_valid), 1);
                chk("hold_y", int'(o_y), prev_y);
                chk("hold_ys", int'(s_y), prev_ys);
            end
            if (o_valid && i_ready) begin
                chk("out_pending", int'(q.size() > 0), 1);
                chk("s_valid", int'(s_valid), 1);
                if (q.size() > 0) begin
                    e_m = q.pop_front();
                    chk("y", int'(o_y), sat(e_m.sum));
                    chk("ys", int'(s_y), sat(shr(e_m.sum)));
                    if (lat_chk) chk("latency", cyc - e_m.cyc, 2);
                end
                rx_y.push_back(int'(o_y));
                rx_ys.push_back(int'(s_y));
            end
            prev_stall = o_valid && !i_ready;
            prev_y     = int'(o_y);
            prev_ys    = int'(s_y);
        end
    end

    int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready
    initial forever begin
        @(posedge clk);
        #1;
        i_ready = (ready_mode == 0) ? 1'b1 : ((ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    task automatic send(input int x, input bit sof);
        int t;
        t = 0;
        i_valid = 1'b1;
        i_x = DATAW'(x);
        i_sof = sof;
        while (1) begin
            @(negedge clk);
            if (o_ready) begin
                model_accept(x, sof, i_f);
                break;
            end
            t++;
            if (t > 500) begin
                chk("send_timeout", t, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_sof = 1'b0;
    endtask

    // mode 0: pixel = row*16+col, 1: constant val, 2: random
    task automatic run_frame(input int nbeats, input int mode, input int val, input bit gaps);
        int r, c, x;
        for (int b = 0; b < nbeats; b++) begin
            r = b / RW;
            c = b % RW;
            x = (mode == 0) ? r * 16 + c : ((mode == 1) ? val : int'($urandom_range(0, 255)));
            send(x, b == 0);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        i_valid = 1'b0;
        i_sof = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_y", int'(o_y), 0);
        chk("rst_ready", int'(o_ready), 1);
        q.delete();
        rx_y.delete();
        rx_ys.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(o_valid), 0);
        chk("post_rst_y", int'(o_y), 0);
        chk("post_rst_ready", int'(o_ready), 1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mkf(input int all, input int ctr);
        logic [FW-1:0] f;
        for (int t = 0; t < K * K; t++)
            f[t*COEFW +: COEFW] = COEFW'((t == (K * K) / 2) ? ctr : all);
        return f;
    endfunction

    task automatic chk_interior(input string nm);
        int e;
        chk({nm, "_cnt"}, rx_y.size(), 3 * IMG_W);
        for (int i = 0; i < rx_y.size() && i < 3 * IMG_W; i++) begin
            e = (i / IMG_W + 1) * 16 + (i % IMG_W) + 1;
            chk(nm, rx_y[i], e);
            chk({nm, "_s"}, rx_ys[i], sat(shr(e)));
        end
        rx_y.delete();
        rx_ys.delete();
    endtask

    typedef struct { int c_all; int c_ctr; int pix; int exp_y; int exp_ys; } vec_t;
    vec_t tbl[6];

    initial begin
        int ev;
        tbl[0] = '{1, 1, 255, 255, 255};
        tbl[1] = '{0, -1, 255, 0, 0};
        tbl[2] = '{1, 1, 3, 27, (R_EN != 0) ? 7 : 6};
        tbl[3] = '{0, 2, 100, 200, 50};
        tbl[4] = '{-1, 9, 10, 10, (R_EN != 0) ? 3 : 2};
        tbl[5] = '{0, -1, 5, 0, 0};

        reset_dut();

        // identity kernel, no backpressure
        ready_mode = 0; lat_chk = 1'b1;
        i_f = mkf(0, 1);
        run_frame(5 * RW, 0, 0, 1'b0);
        drain();
        chk_interior("ident");

        // uniform patches from the table
        for (int v = 0; v < 6; v++) begin
            i_f = mkf(tbl[v].c_all, tbl[v].c_ctr);
            run_frame(3 * RW, 1, tbl[v].pix, 1'b0);
            drain();
            chk("tbl_cnt", rx_y.size(), IMG_W);
            for (int i = 0; i < rx_y.size(); i++) begin
                chk("tbl_y", rx_y[i], tbl[v].exp_y);
                chk("tbl_ys", rx_ys[i], tbl[v].exp_ys);
            end
            rx_y.delete();
            rx_ys.delete();
        end

        // identity kernel under random backpressure
        ready_mode = 1; lat_chk = 1'b0;
        i_f = mkf(0, 1);
        run_frame(5 * RW, 0, 0, 1'b0);
        drain();
        chk_interior("bp");

        // random coefficients and pixels, input gaps and backpressure
        for (int n = 0; n < 3; n++) begin
            for (int t = 0; t < K * K; t++) i_f[t*COEFW +: COEFW] = COEFW'($urandom_range(0, 255));
            run_frame(6 * RW, 2, 0, 1'b1);
            drain();
            chk("rand_cnt", rx_y.size(), 4 * IMG_W);
            rx_y.delete();
            rx_ys.delete();
        end

        // frame restart in the middle of row 3 with new coefficients
        ready_mode = 0; lat_chk = 1'b1;
        i_f = mkf(0, 1);
        run_frame(3 * RW + 5, 0, 0, 1'b0);
        i_f = mkf(1, 1);
        run_frame(3 * RW, 0, 0, 1'b0);
        drain();
        chk("restart_cnt", rx_y.size(), IMG_W + 3 + IMG_W);
        if (rx_y.size() == 2 * IMG_W + 3) begin
            for (int i = 0; i < IMG_W + 3; i++) begin
                ev = (i / IMG_W + 1) * 16 + (i % IMG_W) + 1;
                chk("restart_old", rx_y[i], ev);
            end
            for (int c = 0; c < IMG_W; c++) begin
                ev = 9 * (17 + c);
                chk("restart_new", rx_y[IMG_W + 3 + c], ev);
                chk("restart_new_s", rx_ys[IMG_W + 3 + c], sat(shr(ev)));
            end
        end
        rx_y.delete();
        rx_ys.delete();

        // reset while an output is stalled, then a clean frame
        ready_mode = 2; lat_chk = 1'b0;
        i_f = mkf(0, 1);
        run_frame(2 * RW + 3, 0, 0, 1'b0);
        for (int t = 0; t < 10 && !o_valid; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("stall_valid", int'(o_valid), 1);
        chk("stall_ready", int'(o_ready), 0);
        @(posedge clk);
        #1;
        reset_dut();
        ready_mode = 0; lat_chk = 1'b1;
        @(posedge clk);
        #1;
        i_f = mkf(0, 1);
        run_frame(5 * RW, 0, 0, 1'b0);
        drain();
        chk_interior("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
